// File: rtl/pipe_adder_if.sv
// rtl/pipe_adder_if.sv - operand/result handshake bundle for pipe_adder
//
// Parameter N : operand/result width.
// Upstream   : in_valid, in_ready, a, b, cin, sub
// Downstream : out_valid, out_ready, out, cout, ovf
// master = environment side (drives operands, accepts results)
// slave  = adder side
interface pipe_adder_if #(
    parameter int N = 32
) ();
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out;
    logic         cout;
    logic         ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, out, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, out, cout, ovf
    );
endinterface

// File: rtl/pipe_adder.sv
// rtl/pipe_adder.sv - pipelined ripple-carry adder/subtractor, one chunk per stage
//
// Parameters : N (width), STAGES (depth, N % STAGES == 0, chunk C = N/STAGES)
// Ports      : clk, rst (async, active-high), bus (pipe_adder_if.slave)
//   bus.in_valid/in_ready/a/b/cin/sub    operand handshake
//   bus.out_valid/out_ready/out/cout/ovf result handshake and flags
// Option     : PIPE_ADDER_SAT_EN - clamp out to the signed limit on overflow
module pipe_adder #(
    parameter int N      = 32,
    parameter int STAGES = 4
) (
    input logic         clk,
    input logic         rst,
    pipe_adder_if.slave bus
);
    localparam int C = N / STAGES;

    logic         stall;
    logic         en;
    logic [N-1:0] b_eff;
    logic         c0;

    if ((N % STAGES) != 0) begin : g_bad_cfg
        $error("pipe_adder: N must be a multiple of STAGES");
    end

    // A stalled output freezes the whole pipe, valid bits included.
    assign stall        = bus.out_valid & ~bus.out_ready;
    assign en           = ~stall;
    assign bus.in_ready = ~stall;

    // Subtract is A + ~B + 1; cin only matters in add mode.
    assign b_eff = bus.sub ? ~bus.b : bus.b;
    assign c0    = bus.sub ? 1'b1 : bus.cin;

    // Stage k adds chunk k. Operand chunks above k travel forward in the
    // skew registers (g_op); finished chunks 0..k accumulate in res_q, which
    // acts as the output deskew.
    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int RW = (k + 1) * C;

        logic          vld_d;
        logic          cy_d;
        logic          cy_o;
        logic [C-1:0]  a_c;
        logic [C-1:0]  b_c;
        logic [C-1:0]  s_c;
        logic [RW-1:0] res_raw;
        logic [RW-1:0] res_d;
        logic          vld_q;
        logic          cy_q;
        logic [RW-1:0] res_q;

        if (k == 0) begin : g_src
            assign vld_d   = bus.in_valid;
            assign cy_d    = c0;
            assign a_c     = bus.a[C-1:0];
            assign b_c     = b_eff[C-1:0];
            assign res_raw = s_c;
        end else begin : g_src
            assign vld_d   = g_st[k-1].vld_q;
            assign cy_d    = g_st[k-1].cy_q;
            assign a_c     = g_st[k-1].g_op.a_q[C-1:0];
            assign b_c     = g_st[k-1].g_op.b_q[C-1:0];
            assign res_raw = {s_c, g_st[k-1].res_q};
        end

        assign {cy_o, s_c} = {1'b0, a_c} + {1'b0, b_c} + {{C{1'b0}}, cy_d};

        if (k < STAGES - 1) begin : g_op
            localparam int OW = (STAGES - 1 - k) * C;

            logic [OW-1:0] a_d;
            logic [OW-1:0] b_d;
            logic [OW-1:0] a_q;
            logic [OW-1:0] b_q;

            if (k == 0) begin : g_in
                assign a_d = bus.a[N-1:C];
                assign b_d = b_eff[N-1:C];
            end else begin : g_in
                assign a_d = g_st[k-1].g_op.a_q[OW+C-1:C];
                assign b_d = g_st[k-1].g_op.b_q[OW+C-1:C];
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (en) begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end
        end

        if (k == STAGES - 1) begin : g_fin
            logic ovf_d;
            logic ovf_q;

            // Carry into the MSB is recovered from the MSB sum bit.
            assign ovf_d = (a_c[C-1] ^ b_c[C-1] ^ s_c[C-1]) ^ cy_o;
`ifdef PIPE_ADDER_SAT_EN
            // a_c[C-1] is operand A's MSB, which picks the overflow direction.
            assign res_d = !ovf_d ? res_raw :
                           (a_c[C-1] ? {1'b1, {(RW-1){1'b0}}} : {1'b0, {(RW-1){1'b1}}});
`else
            assign res_d = res_raw;
`endif

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (en) begin
                    ovf_q <= ovf_d;
                end
            end
        end else begin : g_mid
            assign res_d = res_raw;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_q <= 1'b0;
                cy_q  <= 1'b0;
                res_q <= '0;
            end else if (en) begin
                vld_q <= vld_d;
                cy_q  <= cy_o;
                res_q <= res_d;
            end
        end
    end

    assign bus.out_valid = g_st[STAGES-1].vld_q;
    assign bus.out       = g_st[STAGES-1].res_q;
    assign bus.cout      = g_st[STAGES-1].cy_q;
    assign bus.ovf       = g_st[STAGES-1].g_fin.ovf_q;
endmodule

// File: tb/tb_pipe_adder.sv
// tb/tb_pipe_adder.sv - directed bench for pipe_adder at (32,4), (32,1) and (8,8)
module tb_pipe_adder;
`ifdef PIPE_ADDER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        int          d;
        int          lat;
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic [31:0] out;
        logic        cout;
        logic        ovf;
    } vec_t;

    logic        clk;
    logic        rst;
    int          sel;
    logic        drv_valid;
    logic        drv_ordy;
    logic [31:0] drv_a;
    logic [31:0] drv_b;
    logic        drv_cin;
    logic        drv_sub;
    logic        o_valid;
    logic        o_rdy;
    logic [31:0] o_out;
    logic        o_cout;
    logic        o_ovf;
    int          n_vec;
    int          n_bad;
    vec_t        tbl[16];

    pipe_adder_if #(.N(32)) i4 ();
    pipe_adder_if #(.N(32)) i1 ();
    pipe_adder_if #(.N(8))  i8 ();

    pipe_adder #(.N(32), .STAGES(4)) u4 (.clk(clk), .rst(rst), .bus(i4));
    pipe_adder #(.N(32), .STAGES(1)) u1 (.clk(clk), .rst(rst), .bus(i1));
    pipe_adder #(.N(8),  .STAGES(8)) u8 (.clk(clk), .rst(rst), .bus(i8));

    assign i4.in_valid  = drv_valid && (sel == 0);
    assign i1.in_valid  = drv_valid && (sel == 1);
    assign i8.in_valid  = drv_valid && (sel == 2);
    assign i4.a         = drv_a;
    assign i1.a         = drv_a;
    assign i8.a         = drv_a[7:0];
    assign i4.b         = drv_b;
    assign i1.b         = drv_b;
    assign i8.b         = drv_b[7:0];
    assign i4.cin       = drv_cin;
    assign i1.cin       = drv_cin;
    assign i8.cin       = drv_cin;
    assign i4.sub       = drv_sub;
    assign i1.sub       = drv_sub;
    assign i8.sub       = drv_sub;
    assign i4.out_ready = drv_ordy;
    assign i1.out_ready = drv_ordy;
    assign i8.out_ready = drv_ordy;

    always_comb begin
        o_valid = 1'b0;
        o_rdy   = 1'b0;
        o_out   = '0;
        o_cout  = 1'b0;
        o_ovf   = 1'b0;
        case (sel)
            0: begin
                o_valid = i4.out_valid; o_rdy = i4.in_ready; o_out = i4.out;
                o_cout  = i4.cout;      o_ovf = i4.ovf;
            end
            1: begin
                o_valid = i1.out_valid; o_rdy = i1.in_ready; o_out = i1.out;
                o_cout  = i1.cout;      o_ovf = i1.ovf;
            end
            default: begin
                o_valid = i8.out_valid; o_rdy = i8.in_ready; o_out = {24'd0, i8.out};
                o_cout  = i8.cout;      o_ovf = i8.ovf;
            end
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    // Reference: full-width add, flags and clamp, for width w (8 or 32).
    function automatic logic [33:0] model(int w, logic [31:0] a, logic [31:0] b,
                                          logic cin, logic sub);
        logic [31:0] msk;
        logic [31:0] aa;
        logic [31:0] bb;
        logic [32:0] s;
        logic [31:0] r;
        logic        co;
        logic        cm;
        logic        ov;
        msk = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        aa  = a & msk;
        bb  = (sub ? ~b : b) & msk;
        s   = {1'b0, aa} + {1'b0, bb} + (sub ? 33'd1 : {32'd0, cin});
        co  = s[w];
        r   = s[31:0] & msk;
        cm  = aa[w-1] ^ bb[w-1] ^ r[w-1];
        ov  = cm ^ co;
        if (SAT && ov)
            r = aa[w-1] ? (32'd1 << (w - 1)) : ((32'd1 << (w - 1)) - 32'd1);
        return {r, co, ov};
    endfunction

    task automatic run_one(vec_t v, int idx);
        sel = v.d;
        @(negedge clk);
        drv_a = v.a; drv_b = v.b; drv_cin = v.cin; drv_sub = v.sub;
        drv_valid = 1'b1;
        @(posedge clk);
        #1 drv_valid = 1'b0;
        for (int e = 1; e <= v.lat; e++) begin
            @(negedge clk);
            if (e < v.lat) chk($sformatf("v%0d_early_valid", idx), o_valid, 0);
        end
        chk($sformatf("v%0d_valid", idx), o_valid, 1);
        chk($sformatf("v%0d_out", idx), o_out, v.out);
        chk($sformatf("v%0d_cout", idx), o_cout, v.cout);
        chk($sformatf("v%0d_ovf", idx), o_ovf, v.ovf);
    endtask

    // 10 back-to-back operands with out_ready low for 3 cycles mid-stream.
    task automatic stream(int d, int lat, int w);
        logic [31:0] sa[10];
        logic [31:0] sb[10];
        logic        sc[10];
        logic        ss[10];
        logic [33:0] q[$];
        logic [33:0] held;
        logic [33:0] cur;
        logic [33:0] ex;
        logic        prev_st;
        logic        st_win;
        int          idx;
        int          got;
        int          s0;
        idx = 0; got = 0; prev_st = 1'b0; held = '0; s0 = lat + 2;
        for (int i = 0; i < 10; i++) begin
            sa[i] = $urandom; sb[i] = $urandom;
            sc[i] = 1'($urandom_range(0, 1)); ss[i] = 1'($urandom_range(0, 1));
        end
        sel = d;
        for (int cyc = 0; cyc < 80 && got < 10; cyc++) begin
            @(negedge clk);
            st_win   = (cyc >= s0) && (cyc < s0 + 3);
            drv_ordy = !st_win;
            if (idx < 10) begin
                drv_valid = 1'b1;
                drv_a = sa[idx]; drv_b = sb[idx]; drv_cin = sc[idx]; drv_sub = ss[idx];
            end else begin
                drv_valid = 1'b0;
            end
            #1;
            chk($sformatf("s%0d_in_ready_c%0d", d, cyc), o_rdy, st_win ? 0 : 1);
            cur = {o_out, o_cout, o_ovf};
            if (prev_st) chk($sformatf("s%0d_hold_c%0d", d, cyc), {30'd0, cur[1:0]} ^ cur[33:2],
                             {30'd0, held[1:0]} ^ held[33:2]);
            if (o_valid && drv_ordy) begin
                if (q.size() == 0) begin
                    chk($sformatf("s%0d_spurious", d), 1, 0);
                end else begin
                    ex = q.pop_front();
                    chk($sformatf("s%0d_r%0d_out", d, got), o_out, ex[33:2]);
                    chk($sformatf("s%0d_r%0d_flags", d, got), {30'd0, cur[1:0]}, {30'd0, ex[1:0]});
                    got++;
                end
            end
            prev_st = o_valid && !drv_ordy;
            if (prev_st) held = cur;
            if (drv_valid && o_rdy) begin
                q.push_back(model(w, sa[idx], sb[idx], sc[idx], ss[idx]));
                idx++;
            end
        end
        @(negedge clk);
        drv_valid = 1'b0;
        drv_ordy  = 1'b1;
        chk($sformatf("s%0d_count", d), got, 10);
    endtask

    initial begin
        int cnt;
        n_vec = 0; n_bad = 0;
        sel = 0; drv_valid = 1'b0; drv_ordy = 1'b1;
        drv_a = '0; drv_b = '0; drv_cin = 1'b0; drv_sub = 1'b0;

        tbl[0]  = '{0, 4, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        tbl[1]  = '{0, 4, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0,
                    SAT ? 32'h7FFF_FFFF : 32'h8000_0000, 1'b0, 1'b1};
        tbl[2]  = '{0, 4, 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
        tbl[3]  = '{0, 4, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1,
                    SAT ? 32'h8000_0000 : 32'h7FFF_FFFF, 1'b1, 1'b1};
        tbl[4]  = '{0, 4, 32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0, 32'h2222_2222, 1'b0, 1'b0};
        tbl[5]  = '{0, 4, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0,
                    SAT ? 32'h8000_0000 : 32'h0000_0000, 1'b1, 1'b1};
        tbl[6]  = '{0, 4, 32'h00FF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0100_0000, 1'b0, 1'b0};
        tbl[7]  = '{0, 4, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
        tbl[8]  = '{0, 4, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1,
                    SAT ? 32'h7FFF_FFFF : 32'h8000_0000, 1'b0, 1'b1};
        tbl[9]  = '{0, 4, 32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        tbl[10] = '{1, 1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        tbl[11] = '{1, 1, 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
        tbl[12] = '{2, 8, 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        tbl[13] = '{2, 8, 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'h0000_00FE, 1'b0, 1'b0};
        tbl[14] = '{2, 8, 32'h0000_007F, 32'h0000_0001, 1'b0, 1'b0,
                    SAT ? 32'h0000_007F : 32'h0000_0080, 1'b0, 1'b1};
        tbl[15] = '{2, 8, 32'h0000_0080, 32'h0000_0001, 1'b0, 1'b1,
                    SAT ? 32'h0000_0080 : 32'h0000_007F, 1'b1, 1'b1};

        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            sel = d;
            #1;
            chk($sformatf("rst%0d_valid", d), o_valid, 0);
            chk($sformatf("rst%0d_out", d), o_out, 0);
            chk($sformatf("rst%0d_cout", d), o_cout, 0);
            chk($sformatf("rst%0d_ovf", d), o_ovf, 0);
            chk($sformatf("rst%0d_in_ready", d), o_rdy, 1);
        end
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) run_one(tbl[i], i);

        stream(0, 4, 32);
        stream(1, 1, 32);
        stream(2, 8, 8);

        // Reset with three transactions in flight and the first one at the output.
        sel = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drv_a = 32'(i + 1); drv_b = 32'd1; drv_cin = 1'b0; drv_sub = 1'b0;
            drv_valid = 1'b1;
        end
        @(negedge clk);
        drv_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("mid_pre_valid", o_valid, 1);
        chk("mid_pre_out", o_out, 32'd2);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", o_valid, 0);
        chk("mid_rst_out", o_out, 0);
        chk("mid_rst_in_ready", o_rdy, 1);
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (o_valid) cnt++;
        end
        chk("mid_no_emit", cnt, 0);
        run_one(tbl[4], 100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/pipe_adder.md
Name: pipe_adder

Overview:
- Parametrised, pipelined ripple-carry adder/subtractor; next generation of the team's fixed 8-bit ripple adder.
- Splits an N-bit add into STAGES equal chunks and adds one chunk per clock, with the carry held in a register between stages.
- Adds a valid/ready handshake with backpressure, add/subtract mode and status flags.
- Used as the arithmetic primitive for wide datapaths where a full ripple chain does not meet timing.

Parameters:
- N, 32, operand/result width in bits.
- STAGES, 4, pipeline depth; N % STAGES must be 0; chunk width C = N/STAGES.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input operands valid.
- in_ready  out  1  block accepts input this cycle.
- a  in  N  operand A.
- b  in  N  operand B.
- cin  in  1  carry in; used in add mode only.
- sub  in  1  0 = A+B+cin, 1 = A-B.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out  out  N  result.
- cout  out  1  carry out of MSB; in subtract mode 1 = no borrow.
- ovf  out  1  two's-complement signed overflow.

Behaviour:
- Reset: asynchronous and active-high. While rst=1, out_valid=0, out=0, cout=0, ovf=0, and all stage valid bits, carry registers, skew registers and deskew registers are 0. in_ready=1 during and after reset.
- Subtract mode: operand B is inverted (B' = ~b) and the stage-0 carry-in is forced to 1; cin is ignored. Add mode: B' = b, stage-0 carry-in = cin.
- Stage k (0..STAGES-1) computes chunk k = A[kC+C-1:kC] + B'[kC+C-1:kC] + carry_k. carry_k comes from the stage k-1 register; for k=0 it is the stage-0 carry-in.
- Input skew: chunk k of A and B' is delayed k cycles so it meets its carry.
- Output deskew: the result of chunk k is delayed STAGES-1-k cycles so all chunks emerge aligned.
- Latency: exactly STAGES cycles from the accepting edge (in_valid & in_ready) to out_valid=1, when not stalled.
- Throughput: one transaction per cycle.
- Flags: cout = carry out of the final stage. ovf = carry into MSB XOR carry out of MSB, computed in the final stage.
- Stall: stall = out_valid & ~out_ready. in_ready = ~stall.
  - While stalled, every pipeline register holds, including valid bits.
  - out, cout and ovf are stable while out_valid=1 and out_ready=0.
- Bubbles: a stage with valid=0 still clocks its data, but its contents are don't-care. out_valid follows the final valid bit.
- Bubbles are not compressed, and no transaction is ever dropped or duplicated.
- Order: results are strictly FIFO with respect to inputs.
- in_valid=0: nothing is accepted; a and b are ignored.
- STAGES=1 degenerates to a single registered ripple adder with latency 1.
- STAGES=N gives 1-bit chunks.
- Reset mid-operation: all in-flight transactions are discarded. out_valid drops asynchronously, and nothing is emitted after rst deasserts until new input is accepted.

Optional Feature:
- Macro: PIPE_ADDER_SAT_EN.
- Defined: when ovf=1, out is clamped to the signed limit instead of the wrapped sum.
  - Positive overflow (operand A MSB = 0) gives 2^(N-1)-1.
  - Negative overflow (operand A MSB = 1) gives -2^(N-1).
  - ovf and cout are still reported unchanged.
  - The clamp is applied in the final stage; latency is unchanged.
  - The original operand-A MSB must be carried through the pipeline to the final stage for this.
- Not defined: out is the wrapped N-bit sum; no clamp logic is generated.

Test Plan (N=32, STAGES=4 unless stated):
- add: a=0xFFFFFFFF, b=0x00000001, cin=0 -> 4 cycles later out=0x00000000, cout=1, ovf=0.
- add: a=0x7FFFFFFF, b=0x00000001 -> out=0x80000000, ovf=1, cout=0. With PIPE_ADDER_SAT_EN: out=0x7FFFFFFF, ovf=1.
- sub: a=5, b=7 (cin=1, ignored) -> out=0xFFFFFFFE, cout=0, ovf=0. sub: a=0x80000000, b=1 -> out=0x7FFFFFFF, ovf=1 (sat: 0x80000000).
- 10 back-to-back random inputs with out_ready=0 for 3 cycles mid-stream -> in_ready=0 in exactly those cycles, outputs held stable, all 10 results correct and in order.
- 3 transactions in flight, rst pulsed for 1 cycle -> out_valid=0 immediately, no result emitted after reset release; a new input then yields a result after 4 cycles.
- Re-run the first and third scenarios at STAGES=1 (latency 1) and N=8, STAGES=8 (latency 8): 0xFF+0x01 -> out=0x00, cout=1.
